// File: rtl/memwb_arbiter.sv
// Round-robin two-master arbiter for the pipelined Wishbone NOR memory bus; zero added data latency,
// ownership held for a whole cyc. Optional stuck-slave abort via MEMWB_ARB_TIMEOUT_EN.
`ifndef NORADDRBITS
`define NORADDRBITS 24
`endif
`ifndef NORDATABITS
`define NORDATABITS 32
`endif

module memwb_arbiter #(
  parameter int         ADDRBITS       = `NORADDRBITS,
  parameter int         DATABITS       = `NORDATABITS,
`ifdef MEMWB_ARB_TIMEOUT_EN
  parameter int         TIMEOUT_CYCLES = 1023,
`endif
  parameter logic [3:0] MAXOUT         = 4'd15
) (
  input  logic                clk_i,
  input  logic                reset_ni,
  input  logic                m0_cyc_i,
  input  logic                m0_stb_i,
  input  logic                m0_we_i,
  input  logic [ADDRBITS-1:0] m0_adr_i,
  input  logic [DATABITS-1:0] m0_dat_i,
  output logic                m0_ack_o,
  output logic                m0_err_o,
  output logic                m0_stall_o,
  output logic [DATABITS-1:0] m0_dat_o,
  input  logic                m1_cyc_i,
  input  logic                m1_stb_i,
  input  logic                m1_we_i,
  input  logic [ADDRBITS-1:0] m1_adr_i,
  input  logic [DATABITS-1:0] m1_dat_i,
  output logic                m1_ack_o,
  output logic                m1_err_o,
  output logic                m1_stall_o,
  output logic [DATABITS-1:0] m1_dat_o,
  output logic                s_cyc_o,
  output logic                s_stb_o,
  output logic                s_we_o,
  output logic [ADDRBITS-1:0] s_adr_o,
  output logic [DATABITS-1:0] s_dat_o,
  input  logic                s_ack_i,
  input  logic                s_err_i,
  input  logic                s_stall_i,
  input  logic [DATABITS-1:0] s_dat_i,
  output logic [1:0]          grant_o
);

  typedef enum logic [1:0] {IDLE = 2'd0, GNT0 = 2'd1, GNT1 = 2'd2} state_t;

  state_t     state_q, state_d;
  logic       last_q, last_d;
  logic [3:0] outcnt_q, outcnt_d;

  logic                granted, own, full, resp, accept, tmo_hit, gnt_change;
  logic                own_cyc, own_stb, own_we, oth_cyc;
  logic [ADDRBITS-1:0] own_adr;
  logic [DATABITS-1:0] own_dat;

  assign granted    = (state_q != IDLE);
  assign own        = (state_q == GNT1);
  assign own_cyc    = own ? m1_cyc_i : m0_cyc_i;
  assign own_stb    = own ? m1_stb_i : m0_stb_i;
  assign own_we     = own ? m1_we_i  : m0_we_i;
  assign own_adr    = own ? m1_adr_i : m0_adr_i;
  assign own_dat    = own ? m1_dat_i : m0_dat_i;
  assign oth_cyc    = own ? m0_cyc_i : m1_cyc_i;
  assign full       = (outcnt_q == MAXOUT);
  assign resp       = s_ack_i | s_err_i;
  assign gnt_change = (state_d != state_q);

  // Read data is broadcast; only the per-master ack qualifies it.
  assign m0_dat_o = s_dat_i;
  assign m1_dat_o = s_dat_i;
  assign grant_o  = {state_q == GNT1, state_q == GNT0};

  always_comb begin
    s_cyc_o    = 1'b0;
    s_stb_o    = 1'b0;
    s_we_o     = 1'b0;
    s_adr_o    = '0;
    s_dat_o    = '0;
    m0_stall_o = 1'b1;
    m1_stall_o = 1'b1;
    m0_ack_o   = 1'b0;
    m1_ack_o   = 1'b0;
    m0_err_o   = 1'b0;
    m1_err_o   = 1'b0;
    if (granted) begin
      if (!tmo_hit) begin
        s_cyc_o = own_cyc;
        s_stb_o = own_stb & own_cyc & ~full;
      end
      s_we_o  = own_we;
      s_adr_o = own_adr;
      s_dat_o = own_dat;
      if (own) begin
        m1_stall_o = s_stall_i | full;
        m1_ack_o   = s_ack_i;
        m1_err_o   = s_err_i | tmo_hit;
      end else begin
        m0_stall_o = s_stall_i | full;
        m0_ack_o   = s_ack_i;
        m0_err_o   = s_err_i | tmo_hit;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    case (state_q)
      IDLE: begin
        // On a tie the master that did not hold the bus last wins.
        if (m0_cyc_i && m1_cyc_i) state_d = last_q ? GNT0 : GNT1;
        else if (m0_cyc_i)        state_d = GNT0;
        else if (m1_cyc_i)        state_d = GNT1;
      end
      GNT0, GNT1: begin
        if (tmo_hit) begin
          state_d = IDLE;
          last_d  = own;
        end else if (!own_cyc) begin
          state_d = oth_cyc ? (own ? GNT0 : GNT1) : IDLE;
          last_d  = own;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign accept = s_stb_o & ~s_stall_i;

  always_comb begin
    outcnt_d = outcnt_q;
    if (gnt_change) begin
      outcnt_d = '0;
    end else if (accept && !(granted && resp)) begin
      outcnt_d = outcnt_q + 4'd1;
    end else if (!accept && granted && resp && outcnt_q != 4'd0) begin
      outcnt_d = outcnt_q - 4'd1;
    end
  end

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      state_q  <= IDLE;
      last_q   <= 1'b1;
      outcnt_q <= '0;
    end else begin
      state_q  <= state_d;
      last_q   <= last_d;
      outcnt_q <= outcnt_d;
    end
  end

`ifdef MEMWB_ARB_TIMEOUT_EN
  logic [9:0] tmo_q, tmo_d;

  // Fires on the cycle the count would reach TIMEOUT_CYCLES.
  assign tmo_hit = granted && (outcnt_q != 4'd0) && !resp &&
                   (tmo_q == 10'(TIMEOUT_CYCLES - 1));

  always_comb begin
    tmo_d = tmo_q;
    if (gnt_change || resp)                tmo_d = '0;
    else if (granted && outcnt_q != 4'd0)  tmo_d = tmo_q + 10'd1;
  end

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) tmo_q <= '0;
    else           tmo_q <= tmo_d;
  end
`else
  assign tmo_hit = 1'b0;
`endif

endmodule

// File: tb/tb_memwb_arbiter.sv
// Directed self-checking bench for memwb_arbiter: per-cycle vector table plus
// hand-written sequences for ties, pipelining limit, timeout and mid-cycle reset.
module tb_memwb_arbiter;
  localparam int AW = 24;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          reset_ni;
  logic          m0_cyc_i, m0_stb_i, m0_we_i, m1_cyc_i, m1_stb_i, m1_we_i;
  logic [AW-1:0] m0_adr_i, m1_adr_i;
  logic [DW-1:0] m0_dat_i, m1_dat_i;
  logic          m0_ack_o, m0_err_o, m0_stall_o, m1_ack_o, m1_err_o, m1_stall_o;
  logic [DW-1:0] m0_dat_o, m1_dat_o;
  logic          s_cyc_o, s_stb_o, s_we_o;
  logic [AW-1:0] s_adr_o;
  logic [DW-1:0] s_dat_o;
  logic          s_ack_i, s_err_i, s_stall_i;
  logic [DW-1:0] s_dat_i;
  logic [1:0]    grant_o;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  memwb_arbiter #(.ADDRBITS(AW), .DATABITS(DW)) dut (
    .clk_i(clk), .reset_ni(reset_ni),
    .m0_cyc_i(m0_cyc_i), .m0_stb_i(m0_stb_i), .m0_we_i(m0_we_i),
    .m0_adr_i(m0_adr_i), .m0_dat_i(m0_dat_i),
    .m0_ack_o(m0_ack_o), .m0_err_o(m0_err_o), .m0_stall_o(m0_stall_o), .m0_dat_o(m0_dat_o),
    .m1_cyc_i(m1_cyc_i), .m1_stb_i(m1_stb_i), .m1_we_i(m1_we_i),
    .m1_adr_i(m1_adr_i), .m1_dat_i(m1_dat_i),
    .m1_ack_o(m1_ack_o), .m1_err_o(m1_err_o), .m1_stall_o(m1_stall_o), .m1_dat_o(m1_dat_o),
    .s_cyc_o(s_cyc_o), .s_stb_o(s_stb_o), .s_we_o(s_we_o), .s_adr_o(s_adr_o), .s_dat_o(s_dat_o),
    .s_ack_i(s_ack_i), .s_err_i(s_err_i), .s_stall_i(s_stall_i), .s_dat_i(s_dat_i),
    .grant_o(grant_o)
  );

  // {grant[1:0], s_cyc, s_stb, m0_stall, m1_stall, m0_ack, m1_ack, m0_err, m1_err}
  wire [9:0] obs = {grant_o, s_cyc_o, s_stb_o, m0_stall_o, m1_stall_o,
                    m0_ack_o, m1_ack_o, m0_err_o, m1_err_o};
  localparam logic [9:0] OBS_IDLE = 10'b00_0011_0000;

  typedef struct {
    logic          m0c, m0s, m1c, m1s, ack, err, stall;
    logic [9:0]    exp;
    logic [AW-1:0] adr;
  } vec_t;

  vec_t vt[11];

  function automatic vec_t mk(input logic m0c, m0s, m1c, m1s, ack, err, stall,
                              input logic [9:0] exp, input logic [AW-1:0] adr);
    vec_t v;
    v.m0c = m0c; v.m0s = m0s; v.m1c = m1c; v.m1s = m1s;
    v.ack = ack; v.err = err; v.stall = stall; v.exp = exp; v.adr = adr;
    return v;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    m0_cyc_i = 0; m0_stb_i = 0; m0_we_i = 0; m1_cyc_i = 0; m1_stb_i = 0; m1_we_i = 0;
    s_ack_i = 0; s_err_i = 0; s_stall_i = 0;
  endtask

  task automatic do_reset();
    idle_inputs();
    reset_ni = 1'b0;
    repeat (2) @(posedge clk);
    #2 reset_ni = 1'b1;
  endtask

  int acc;
  int errk;
  logic scyc_at;

  initial begin
    m0_adr_i = 24'h000100; m1_adr_i = 24'h000200;
    m0_dat_i = 32'hCAFE0001; m1_dat_i = 32'hBEEF0002;
    s_dat_i  = 32'h0;
    idle_inputs();
    reset_ni = 1'b0;
    #3;
    check("reset_outputs", obs, OBS_IDLE);
    check("reset_s_adr", s_adr_o, 0);
    check("reset_s_we_dat", {s_we_o, s_dat_o}, 0);
    repeat (2) @(posedge clk);
    #2 reset_ni = 1'b1;

    vt[0]  = mk(0,0,0,0,0,0,0, OBS_IDLE,        24'h0);
    vt[1]  = mk(1,1,0,0,0,0,0, OBS_IDLE,        24'h0);
    vt[2]  = mk(1,1,0,0,0,0,0, 10'b01_1101_0000, 24'h100);
    vt[3]  = mk(1,1,0,0,0,0,1, 10'b01_1111_0000, 24'h100);
    vt[4]  = mk(1,0,1,1,1,0,0, 10'b01_1001_1000, 24'h100);
    vt[5]  = mk(0,0,1,1,0,0,0, 10'b01_0001_0000, 24'h100);
    vt[6]  = mk(0,0,1,1,0,0,0, 10'b10_1110_0000, 24'h200);
    vt[7]  = mk(0,0,1,0,0,1,0, 10'b10_1010_0001, 24'h200);
    vt[8]  = mk(1,0,0,0,0,0,0, 10'b10_0010_0000, 24'h200);
    vt[9]  = mk(0,0,0,0,0,0,0, 10'b01_0001_0000, 24'h100);
    vt[10] = mk(0,0,0,0,1,1,0, OBS_IDLE,        24'h0);

    for (int i = 0; i < 11; i++) begin
      tick();
      m0_cyc_i = vt[i].m0c; m0_stb_i = vt[i].m0s;
      m1_cyc_i = vt[i].m1c; m1_stb_i = vt[i].m1s;
      s_ack_i = vt[i].ack; s_err_i = vt[i].err; s_stall_i = vt[i].stall;
      s_dat_i = 32'h12345600 + i;
      #3;
      check($sformatf("vec%0d_ctl", i), obs, vt[i].exp);
      check($sformatf("vec%0d_adr", i), s_adr_o, vt[i].adr);
      if (i == 4) check("m0_rdata", m0_dat_o, 32'h12345604);
    end

    // Tie from reset, handover gap, then alternation.
    do_reset();
    tick(); m0_cyc_i = 1; m1_cyc_i = 1; #3;
    tick(); #3; check("tie1_m0_first", grant_o, 2'b01);
    tick(); m0_cyc_i = 0; #3;
    check("handover_gap", {grant_o, s_cyc_o}, 3'b010);
    tick(); #3; check("handover_m1", {grant_o, s_cyc_o}, 3'b101);
    tick(); m1_cyc_i = 0; #3;
    tick(); m0_cyc_i = 1; m1_cyc_i = 1; #3;
    tick(); #3; check("tie2_m0", grant_o, 2'b01);
    tick(); m0_cyc_i = 0; m1_cyc_i = 0; #3;
    tick(); m0_cyc_i = 1; m1_cyc_i = 1; #3;
    tick(); #3; check("tie3_m1", grant_o, 2'b10);

    // Outstanding-strobe limit.
    do_reset();
    tick(); m0_cyc_i = 1; m0_stb_i = 1; m0_we_i = 1; #3;
    acc = 0;
    for (int k = 0; k < 20; k++) begin
      tick(); #3;
      if (s_stb_o && !s_stall_i) acc++;
    end
    check("accepted_strobes", acc, 15);
    check("stall_when_full", {m0_stall_o, s_stb_o}, 2'b10);
    check("write_mirror", {s_we_o, s_dat_o}, {1'b1, 32'hCAFE0001});
    tick(); s_ack_i = 1; #3;
    check("stall_in_ack_cycle", m0_stall_o, 1);
    tick(); s_ack_i = 0; #3;
    check("stall_release", {m0_stall_o, s_stb_o}, 2'b01);

    // Unacknowledged single strobe.
    do_reset();
    tick(); m0_cyc_i = 1; m0_stb_i = 1; #3;
    tick(); #3;
    errk = -1; scyc_at = 1'b1;
    for (int k = 1; k <= 1100 && errk < 0; k++) begin
      tick(); m0_stb_i = 0; #3;
      if (m0_err_o) begin
        errk = k;
        scyc_at = s_cyc_o;
      end
    end
`ifdef MEMWB_ARB_TIMEOUT_EN
    check("timeout_cycle", errk, 1023);
    check("timeout_scyc_low", scyc_at, 0);
    tick(); #3; check("timeout_idle", grant_o, 2'b00);
`else
    check("no_timeout_err", errk, -1);
    check("bus_held", {grant_o, s_cyc_o}, 3'b011);
`endif

    // Reset asserted mid-burst while slave acks.
    do_reset();
    tick(); m1_cyc_i = 1; m1_stb_i = 1; #3;
    tick(); #3; check("gnt1_burst", grant_o, 2'b10);
    tick(); s_ack_i = 1; #2;
    reset_ni = 1'b0; #1;
    check("async_reset", obs, OBS_IDLE);
    m0_cyc_i = 1;
    @(posedge clk); #2;
    reset_ni = 1'b1; s_ack_i = 0;
    tick(); #3; check("post_reset_m0", grant_o, 2'b01);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
